// File: rtl/muldiv_nbit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_nbit_pkg;

    localparam int unsigned SIZE_DEF = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } eng_state_t;

endpackage

// File: rtl/muldiv_nbit_if.sv
// Handshake and operand/result bundle for the multiply/divide unit.
interface muldiv_nbit_if #(
    parameter int unsigned SIZE = muldiv_nbit_pkg::SIZE_DEF
);
    logic                div_start;
    logic                div_ready;
    logic                div_valid;
    logic                div_error;
    logic                div_is_signed;
    logic [SIZE-1:0]     dividend;
    logic [SIZE-1:0]     divisor;
    logic [SIZE-1:0]     quotient;
    logic [SIZE-1:0]     remainder;
    logic                mul_start;
    logic                mul_ready;
    logic                mul_valid;
    logic                mul_is_signed;
    logic [SIZE-1:0]     multiplicand;
    logic [SIZE-1:0]     multiplier;
    logic [2*SIZE-1:0]   product;

    modport master (
        output div_start, div_is_signed, dividend, divisor,
        output mul_start, mul_is_signed, multiplicand, multiplier,
        input  div_ready, div_valid, div_error, quotient, remainder,
        input  mul_ready, mul_valid, product
    );

    modport slave (
        input  div_start, div_is_signed, dividend, divisor,
        input  mul_start, mul_is_signed, multiplicand, multiplier,
        output div_ready, div_valid, div_error, quotient, remainder,
        output mul_ready, mul_valid, product
    );
endinterface

// File: rtl/muldiv_nbit_div.sv
// Restoring radix-2 divider: magnitude setup, SIZE quotient-bit cycles, sign fix-up.
module div_nbit_core
    import muldiv_nbit_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            ready,
    output logic            valid,
    output logic            error,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder
);

    localparam int unsigned CW = $clog2(SIZE + 1);

    eng_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] dvd_q, dvd_d;
    logic [SIZE-1:0] dvs_q, dvs_d;
    logic [SIZE-1:0] rem_q, rem_d;
    logic            sgn_q, sgn_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            ready_d, valid_d, error_d;
    logic [SIZE-1:0] quotient_d, remainder_d;
    logic [SIZE:0]   trial, diff;
    logic            ge;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        sgn_d       = sgn_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        valid_d     = 1'b0;
        error_d     = error;
        quotient_d  = quotient;
        remainder_d = remainder;
        trial       = {rem_q, dvd_q[SIZE-1]};
        diff        = trial - {1'b0, dvs_q};
        ge          = (trial >= {1'b0, dvs_q});

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = is_signed;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    // Zero divisor short-circuits before any iteration.
                    if (dvs_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = dvd_q;
                        error_d     = 1'b1;
                        valid_d     = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        negr_d = sgn_q & dvd_q[SIZE-1];
                        negq_d = sgn_q & (dvd_q[SIZE-1] ^ dvs_q[SIZE-1]);
                        dvd_d  = (sgn_q & dvd_q[SIZE-1]) ? SIZE'(-dvd_q) : dvd_q;
                        dvs_d  = (sgn_q & dvs_q[SIZE-1]) ? SIZE'(-dvs_q) : dvs_q;
                        rem_d  = '0;
                        cnt_d  = CW'(1);
                    end
                end else begin
                    rem_d = SIZE'(ge ? diff : trial);
                    dvd_d = {dvd_q[SIZE-2:0], ge};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SIZE)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                quotient_d  = negq_q ? SIZE'(-dvd_q) : dvd_q;
                remainder_d = negr_q ? SIZE'(-rem_q) : rem_q;
                error_d     = 1'b0;
                valid_d     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            sgn_q     <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            ready     <= 1'b1;
            valid     <= 1'b0;
            error     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            sgn_q     <= sgn_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            ready     <= ready_d;
            valid     <= valid_d;
            error     <= error_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
        end
    end

endmodule

// File: rtl/muldiv_nbit_mul.sv
// Shift-add multiplier on operand magnitudes with a final sign fix-up cycle.
module mul_nbit_core
    import muldiv_nbit_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic [SIZE-1:0]   multiplicand,
    input  logic [SIZE-1:0]   multiplier,
    output logic              ready,
    output logic              valid,
    output logic [2*SIZE-1:0] product
);

    localparam int unsigned CW = $clog2(SIZE + 1);

    eng_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SIZE-1:0]   mcand_q, mcand_d;
    logic [2*SIZE:0]   acc_q, acc_d;
    logic              sgn_q, sgn_d;
    logic              neg_q, neg_d;
    logic              ready_d, valid_d;
    logic [2*SIZE-1:0] product_d;
    logic [SIZE:0]     sum;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        sgn_d     = sgn_q;
        neg_d     = neg_q;
        valid_d   = 1'b0;
        product_d = product;
        sum       = acc_q[2*SIZE:SIZE] + (SIZE+1)'(acc_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = multiplicand;
                    acc_d   = {(SIZE+1)'(0), multiplier};
                    sgn_d   = is_signed;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    neg_d   = sgn_q & (mcand_q[SIZE-1] ^ acc_q[SIZE-1]);
                    mcand_d = (sgn_q & mcand_q[SIZE-1]) ? SIZE'(-mcand_q) : mcand_q;
                    acc_d   = {(SIZE+1)'(0),
                               (sgn_q & acc_q[SIZE-1]) ? SIZE'(-acc_q[SIZE-1:0])
                                                       : acc_q[SIZE-1:0]};
                    cnt_d   = CW'(1);
                end else begin
                    // Upper half accumulates, whole register shifts right one bit.
                    acc_d = {1'b0, sum, acc_q[SIZE-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SIZE)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                product_d = neg_q ? (2*SIZE)'(-acc_q[2*SIZE-1:0]) : acc_q[2*SIZE-1:0];
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            ready   <= 1'b1;
            valid   <= 1'b0;
            product <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            ready   <= ready_d;
            valid   <= valid_d;
            product <= product_d;
        end
    end

endmodule

// File: rtl/muldiv_nbit.sv
// Multiply/divide unit: independent divider and multiplier engines side by side.
module muldiv_nbit
    import muldiv_nbit_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_nbit_if.slave bus
);

    div_nbit_core #(.SIZE(SIZE)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (bus.div_start),
        .is_signed (bus.div_is_signed),
        .dividend  (bus.dividend),
        .divisor   (bus.divisor),
        .ready     (bus.div_ready),
        .valid     (bus.div_valid),
        .error     (bus.div_error),
        .quotient  (bus.quotient),
        .remainder (bus.remainder)
    );

    mul_nbit_core #(.SIZE(SIZE)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (bus.mul_start),
        .is_signed    (bus.mul_is_signed),
        .multiplicand (bus.multiplicand),
        .multiplier   (bus.multiplier),
        .ready        (bus.mul_ready),
        .valid        (bus.mul_valid),
        .product      (bus.product)
    );

endmodule

// File: tb/tb_muldiv_nbit.sv
// Scoreboard bench for muldiv_nbit: directed vectors, monitors compare on valid.
module tb_muldiv_nbit;

    localparam int unsigned W = 33;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        int           acc;
        int           lat;
    } div_exp_t;

    typedef struct {
        logic [2*W-1:0] p;
        int             acc;
        int             lat;
    } mul_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    div_exp_t div_sb[$];
    mul_exp_t mul_sb[$];

    muldiv_nbit_if #(.SIZE(W)) bus ();

    muldiv_nbit #(.SIZE(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider monitor: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.div_valid) begin
            if (div_sb.size() == 0) begin
                chk("div_unexpected_valid", 1, 0);
            end else begin
                div_exp_t e;
                e = div_sb.pop_front();
                chk("div_quotient", (2*W)'(bus.quotient), (2*W)'(e.q));
                chk("div_remainder", (2*W)'(bus.remainder), (2*W)'(e.r));
                chk("div_error", (2*W)'(bus.div_error), (2*W)'(e.err));
                chk("div_latency", (2*W)'(cyc - e.acc), (2*W)'(e.lat));
                chk("div_ready_at_valid", (2*W)'(bus.div_ready), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.mul_valid) begin
            if (mul_sb.size() == 0) begin
                chk("mul_unexpected_valid", 1, 0);
            end else begin
                mul_exp_t e;
                e = mul_sb.pop_front();
                chk("mul_product", bus.product, e.p);
                chk("mul_latency", (2*W)'(cyc - e.acc), (2*W)'(e.lat));
                chk("mul_ready_at_valid", (2*W)'(bus.mul_ready), 1);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic err,
                          input int lat);
        div_exp_t e;
        int n = 0;
        while (!bus.div_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.div_ready) chk("div_ready_timeout", 0, 1);
        bus.dividend      = a;
        bus.divisor       = b;
        bus.div_is_signed = s;
        bus.div_start     = 1'b1;
        e.q = q; e.r = r; e.err = err; e.acc = cyc + 1; e.lat = lat;
        div_sb.push_back(e);
        @(negedge clk);
        bus.div_start = 1'b0;
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [2*W-1:0] p);
        mul_exp_t e;
        int n = 0;
        while (!bus.mul_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mul_ready) chk("mul_ready_timeout", 0, 1);
        bus.multiplicand  = a;
        bus.multiplier    = b;
        bus.mul_is_signed = s;
        bus.mul_start     = 1'b1;
        e.p = p; e.acc = cyc + 1; e.lat = 35;
        mul_sb.push_back(e);
        @(negedge clk);
        bus.mul_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((div_sb.size() != 0 || mul_sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (div_sb.size() != 0 || mul_sb.size() != 0) begin
            chk("idle_timeout", 1, 0);
            div_sb.delete();
            mul_sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.div_start = 1'b0; bus.div_is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        bus.mul_start = 1'b0; bus.mul_is_signed = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        repeat (2) @(negedge clk);
        chk("rst_div_ready", (2*W)'(bus.div_ready), 1);
        chk("rst_mul_ready", (2*W)'(bus.mul_ready), 1);
        chk("rst_valids", (2*W)'({bus.div_valid, bus.mul_valid, bus.div_error}), 0);
        chk("rst_quotient", (2*W)'(bus.quotient), 0);
        chk("rst_product", bus.product, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(33'd100, 33'd7, 1'b1, 33'd14, 33'd2, 1'b0, 35);
        chk("div_busy_ready_low", (2*W)'(bus.div_ready), 0);
        wait_idle();
        do_div(33'h1_FFFF_FFF9, 33'd2, 1'b1, 33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF, 1'b0, 35);
        wait_idle();
        do_div(33'h1_FFFF_FFF9, 33'h1_FFFF_FFFE, 1'b1, 33'd3, 33'h1_FFFF_FFFF, 1'b0, 35);
        wait_idle();
        do_div(33'h0_FFFF_FFFF, 33'h0_0000_0010, 1'b0, 33'h0_0FFF_FFFF, 33'hF, 1'b0, 35);
        wait_idle();
        do_div(33'd5, 33'd0, 1'b1, 33'h1_FFFF_FFFF, 33'd5, 1'b1, 1);
        wait_idle();
        do_div(33'h1_0000_0000, 33'h1_FFFF_FFFF, 1'b1, 33'h1_0000_0000, 33'd0, 1'b0, 35);
        wait_idle();

        // Concurrent engines: divide and multiply in flight together.
        do_div(33'd1000, 33'd10, 1'b0, 33'd100, 33'd0, 1'b0, 35);
        do_mul(33'h1_FFFF_FFFD, 33'd5, 1'b1, 66'h3_FFFF_FFFF_FFFF_FFF1);
        wait_idle();
        do_mul(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0, 66'h0_FFFF_FFFE_0000_0001);
        wait_idle();
        do_mul(33'h1_FFFF_FFFD, 33'h1_FFFF_FFFB, 1'b1, 66'd15);
        wait_idle();

        // Start while busy must be ignored.
        do_mul(33'd12, 33'd11, 1'b0, 66'd132);
        repeat (4) @(negedge clk);
        bus.multiplicand = 33'd7; bus.multiplier = 33'd7; bus.mul_is_signed = 1'b1;
        bus.mul_start = 1'b1;
        @(negedge clk);
        bus.mul_start = 1'b0;
        wait_idle();

        // Back-to-back: new start in the valid cycle; old result held meanwhile.
        do_div(33'd100, 33'd7, 1'b0, 33'd14, 33'd2, 1'b0, 35);
        begin
            int n = 0;
            while (!bus.div_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (!bus.div_valid) chk("b2b_valid_timeout", 0, 1);
        end
        do_div(33'd50, 33'd6, 1'b0, 33'd8, 33'd2, 1'b0, 35);
        repeat (10) @(negedge clk);
        chk("b2b_old_quotient_held", (2*W)'(bus.quotient), 66'd14);
        wait_idle();

        // Reset at cycle 10 of a divide: idle, cleared, no late valid.
        do_div(33'd77, 33'd3, 1'b0, 33'd25, 33'd2, 1'b0, 35);
        repeat (8) @(negedge clk);
        div_sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_div_ready", (2*W)'(bus.div_ready), 1);
        chk("midrst_div_valid", (2*W)'(bus.div_valid), 0);
        chk("midrst_quotient", (2*W)'(bus.quotient), 0);
        chk("midrst_remainder", (2*W)'(bus.remainder), 0);
        chk("midrst_product", bus.product, 0);
        repeat (50) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_nbit.md
Name: muldiv_nbit

Overview:
- Iterative integer multiply/divide unit for the execute stage's RV32M path.
- Holds two independent sequential engines (divider, multiplier), each with its own start/ready/valid handshake, operating on SIZE-bit operands.
- The execute stage drives 33-bit sign- or zero-extended 32-bit operands so one signed engine covers DIV/DIVU/REM/REMU and MUL/MULH/MULHU/MULHSU.

Parameters:
- SIZE, 33, operand width in bits; product is 2*SIZE bits.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- div_start  in  1  request a division; accepted only when div_ready=1
- div_ready  out  1  divider idle, can accept div_start
- div_valid  out  1  one-cycle pulse, divide result available
- div_error  out  1  set together with div_valid when divisor==0
- div_is_signed  in  1  two's-complement operands when 1
- dividend  in  SIZE  sampled at accepted start
- divisor  in  SIZE  sampled at accepted start
- quotient  out  SIZE  registered result
- remainder  out  SIZE  registered result
- mul_start  in  1  request a multiply; accepted only when mul_ready=1
- mul_ready  out  1  multiplier idle
- mul_valid  out  1  one-cycle pulse, product available
- mul_is_signed  in  1  both operands two's-complement when 1
- multiplicand  in  SIZE  sampled at accepted start
- multiplier  in  SIZE  sampled at accepted start
- product  out  2*SIZE  registered result

Behaviour:
- Reset (rst_n=0 at an edge):
  - ready=1, valid=0, div_error=0.
  - quotient, remainder and product are cleared to 0.
  - Any in-flight operation is aborted.
- Start accepted when start && ready at an edge (edge 0).
  - Operands and the is_signed bit are latched at edge 0.
  - ready drops after edge 0.
  - start while busy is ignored; the latched operands are unaffected.
- Divider:
  - Signed mode: the engine takes operand magnitudes, runs a restoring radix-2 loop for SIZE cycles (one quotient bit per cycle, MSB first), then spends one fix-up cycle applying signs.
  - Quotient truncates toward zero. Remainder takes the dividend's sign.
  - quotient/remainder update and div_valid=1 after edge SIZE+2 (35 cycles for SIZE=33). ready returns to 1 in the same cycle.
  - Divisor==0 takes a fast path: after edge 1, div_valid=1, div_error=1, quotient=all ones, remainder=dividend.
  - Signed overflow (most-negative / -1): quotient=dividend, remainder=0, div_error=0, normal latency.
- Multiplier:
  - Shift-add on magnitudes for SIZE cycles, then one sign fix-up cycle.
  - product = full 2*SIZE-bit exact product (signed or unsigned per mul_is_signed).
  - Valid after edge SIZE+2.
- Output timing (both engines):
  - valid is high for exactly one cycle.
  - Results hold their values until the next completion or reset.
- A start in the valid cycle (ready=1) is accepted and begins a new operation; the previous results stay visible until that operation completes.
- The two engines never interact; both may run concurrently.
- Reset mid-operation: after the reset edge, ready=1, valid=0, and no late valid pulse follows.

Decomposition:
- Shared package holds:
  - localparam defaults (SIZE=33)
  - engine state enum IDLE / RUN / FIX
- Sub-modules:
  - div_nbit_core: divider FSM + datapath.
  - mul_nbit_core: multiplier FSM + datapath.
  - muldiv_nbit is a thin wrapper instantiating one of each.

Test Plan:
- Signed divide: dividend=100, divisor=7, signed -> quotient=14, remainder=2, div_valid exactly 35 cycles after start, div_error=0.
- Signed negative divide: dividend=0x1_FFFF_FFF9 (-7), divisor=2, signed -> quotient=0x1_FFFF_FFFD (-3), remainder=0x1_FFFF_FFFF (-1). Unsigned 0x0_FFFF_FFFF/0x0_0000_0010 -> quotient=0x0_0FFF_FFFF, remainder=0xF.
- Divide by zero: dividend=5, divisor=0 -> one cycle later div_valid=1, div_error=1, quotient=0x1_FFFF_FFFF, remainder=5; div_ready=1 that cycle.
- Multiply, signed: -3 × 5 -> product = 66-bit -15 (all ones except low 0x...F1), valid at cycle 35.
- Multiply, unsigned: 0x0_FFFF_FFFF × 0x0_FFFF_FFFF -> product=0xFFFF_FFFE_0000_0001.
- Handshake and reset:
  - mul_start pulsed while busy -> ignored, original result returned.
  - rst_n=0 at cycle 10 of a divide -> ready=1, outputs 0, no valid pulse afterwards.
  - Back-to-back start in the valid cycle -> second result after a further 35 cycles.
